controle_exploracao: RTL and testbench

Sequencing controller for the `distancias` nearest-target search engine in the exploration datapath. It does five things:
- captures robot position updates and map-change events;
- launches one `distancias` search at a time with a single-cycle `novoDado` pulse;
- supervises completion with a timeout and bounded retries;
- detects "no target left";
- hands the chosen destination to the motion stage over a valid/ready handshake.

---
 rtl/exploracao_pkg.sv | 17 +
 rtl/controle_exploracao_if.sv | 39 +++
 rtl/temporizador_busca.sv | 29 ++
 rtl/controle_exploracao.sv | 136 +++++++++++++
 tb/tb_controle_exploracao.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/exploracao_pkg.sv
// Shared types and default sizes for the exploration sequencing controller.
package exploracao_pkg;
  localparam int TAMANHO_DISTANCIA     = 8;
  localparam int TIMEOUT_CICLOS_PADRAO = 1024;
  localparam int MAX_TENTATIVAS_PADRAO = 2;
  localparam int TIMER_W               = $clog2(TIMEOUT_CICLOS_PADRAO);

  typedef logic [TAMANHO_DISTANCIA-1:0] coord_t;

  typedef enum logic [2:0] {
    OCIOSO,
    DISPARA,
    AGUARDA,
    ENTREGA,
    FALHA
  } estado_t;
endpackage

// File: rtl/controle_exploracao_if.sv
// Bundle of the position/map strobes, the distancias engine link and the motion-stage handshake.
interface controle_exploracao_if #(
  parameter int tamanhoDistancia = exploracao_pkg::TAMANHO_DISTANCIA
);
  logic                        habilita;
  logic                        posicaoValida;
  logic [tamanhoDistancia-1:0] posicaoX;
  logic [tamanhoDistancia-1:0] posicaoY;
  logic                        malhaAtualizada;
  logic                        novoDado;
  logic [tamanhoDistancia-1:0] buscaX;
  logic [tamanhoDistancia-1:0] buscaY;
  logic                        operacaoFinalizada;
  logic [tamanhoDistancia-1:0] resultadoX;
  logic [tamanhoDistancia-1:0] resultadoY;
  logic                        destinoValido;
  logic                        destinoPronto;
  logic [tamanhoDistancia-1:0] destinoX;
  logic [tamanhoDistancia-1:0] destinoY;
  logic                        semAlvo;
  logic                        ocupado;
  logic                        falha;

  // Controller side.
  modport master (
    input  habilita, posicaoValida, posicaoX, posicaoY, malhaAtualizada,
    input  operacaoFinalizada, resultadoX, resultadoY, destinoPronto,
    output novoDado, buscaX, buscaY, destinoValido, destinoX, destinoY,
    output semAlvo, ocupado, falha
  );

  // Environment side: position source, search engine and motion stage.
  modport slave (
    output habilita, posicaoValida, posicaoX, posicaoY, malhaAtualizada,
    output operacaoFinalizada, resultadoX, resultadoY, destinoPronto,
    input  novoDado, buscaX, buscaY, destinoValido, destinoX, destinoY,
    input  semAlvo, ocupado, falha
  );
endinterface

// File: rtl/temporizador_busca.sv
// Search watchdog: cleared on each launch, counts while a search is outstanding.
module temporizador_busca
  import exploracao_pkg::*;
#(
  parameter int TIMEOUT_CICLOS = TIMEOUT_CICLOS_PADRAO
) (
  input  logic clock,
  input  logic reset,
  input  logic limpa,
  input  logic conta,
  output logic terminal
);
  localparam int TW = (TIMEOUT_CICLOS > 1) ? $clog2(TIMEOUT_CICLOS) : 1;
  localparam logic [TW-1:0] ULTIMO = TW'(TIMEOUT_CICLOS - 1);

  logic [TW-1:0] r_contagem;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_contagem <= '0;
    end else if (limpa) begin
      r_contagem <= '0;
    end else if (conta) begin
      r_contagem <= r_contagem + 1'b1;
    end
  end

  assign terminal = (r_contagem == ULTIMO);
endmodule

// File: rtl/controle_exploracao.sv
// Launches one distancias search at a time, supervises it with timeout/retry and
// hands the resulting destination to the motion stage.
module controle_exploracao
  import exploracao_pkg::*;
#(
  parameter int tamanhoDistancia = TAMANHO_DISTANCIA,
  parameter int TIMEOUT_CICLOS   = TIMEOUT_CICLOS_PADRAO,
  parameter int MAX_TENTATIVAS   = MAX_TENTATIVAS_PADRAO
) (
  input logic                   clock,
  input logic                   reset,
  controle_exploracao_if.master bus
);
  localparam int TENT_W = $clog2(MAX_TENTATIVAS + 1);
  localparam logic [TENT_W-1:0] MAX_T = TENT_W'(MAX_TENTATIVAS);

  estado_t                     r_estado;
  estado_t                     w_prox;
  logic [tamanhoDistancia-1:0] r_posX, r_posY;
  logic [tamanhoDistancia-1:0] r_buscaX, r_buscaY;
  logic [tamanhoDistancia-1:0] r_destX, r_destY;
  logic                        r_conhecida;
  logic                        r_pendente;
  logic [TENT_W-1:0]           r_tent;
  logic                        r_semAlvo;
  logic                        r_fin_ant;

  logic w_strobe, w_pend_ef, w_conh_ef, w_fim, w_mesmo, w_tc;
  logic w_lanca, w_relanca, w_captura, w_sem_set;

  assign w_strobe  = bus.posicaoValida | bus.malhaAtualizada;
  assign w_pend_ef = r_pendente | w_strobe;
  assign w_conh_ef = r_conhecida | bus.posicaoValida;
  // Only a fresh rising edge counts; a level left high from before is not a completion.
  assign w_fim     = bus.operacaoFinalizada & ~r_fin_ant;
  assign w_mesmo   = (bus.resultadoX == r_buscaX) && (bus.resultadoY == r_buscaY);

  temporizador_busca #(
    .TIMEOUT_CICLOS(TIMEOUT_CICLOS)
  ) u_temporizador (
    .clock    (clock),
    .reset    (reset),
    .limpa    (w_lanca | w_relanca),
    .conta    ((r_estado == DISPARA) || (r_estado == AGUARDA)),
    .terminal (w_tc)
  );

  always_comb begin
    w_prox    = r_estado;
    w_lanca   = 1'b0;
    w_relanca = 1'b0;
    w_captura = 1'b0;
    w_sem_set = 1'b0;
    case (r_estado)
      OCIOSO: begin
        if (bus.habilita && w_pend_ef && w_conh_ef) begin
          w_prox  = DISPARA;
          w_lanca = 1'b1;
        end
      end
      DISPARA: w_prox = AGUARDA;
      AGUARDA: begin
        if (w_fim) begin
          if (w_mesmo) begin
            w_prox    = OCIOSO;
            w_sem_set = 1'b1;
          end else begin
            w_prox    = ENTREGA;
            w_captura = 1'b1;
          end
        end else if (w_tc) begin
          if (r_tent < MAX_T) begin
            w_prox    = DISPARA;
            w_relanca = 1'b1;
          end else begin
            w_prox = FALHA;
          end
        end
      end
      ENTREGA: begin
        if (bus.destinoPronto) w_prox = OCIOSO;
      end
      FALHA:   w_prox = FALHA;
      default: w_prox = OCIOSO;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_estado    <= OCIOSO;
      r_posX      <= '0;
      r_posY      <= '0;
      r_buscaX    <= '0;
      r_buscaY    <= '0;
      r_destX     <= '0;
      r_destY     <= '0;
      r_conhecida <= 1'b0;
      r_pendente  <= 1'b0;
      r_tent      <= '0;
      r_semAlvo   <= 1'b0;
      r_fin_ant   <= 1'b0;
    end else begin
      r_estado  <= w_prox;
      r_fin_ant <= bus.operacaoFinalizada;
      if (bus.posicaoValida) begin
        r_posX      <= bus.posicaoX;
        r_posY      <= bus.posicaoY;
        r_conhecida <= 1'b1;
      end
      // A strobe in the launch cycle re-arms pendente so a follow-up search is owed.
      r_pendente <= w_strobe | (r_pendente & ~w_lanca);
      if (w_lanca) begin
        r_buscaX  <= bus.posicaoValida ? bus.posicaoX : r_posX;
        r_buscaY  <= bus.posicaoValida ? bus.posicaoY : r_posY;
        r_tent    <= TENT_W'(1);
        r_semAlvo <= 1'b0;
      end
      if (w_relanca) r_tent <= r_tent + 1'b1;
      if (w_captura) begin
        r_destX <= bus.resultadoX;
        r_destY <= bus.resultadoY;
      end
      if (w_sem_set) r_semAlvo <= 1'b1;
    end
  end

  assign bus.novoDado      = (r_estado == DISPARA);
  assign bus.buscaX        = r_buscaX;
  assign bus.buscaY        = r_buscaY;
  assign bus.destinoValido = (r_estado == ENTREGA);
  assign bus.destinoX      = r_destX;
  assign bus.destinoY      = r_destY;
  assign bus.semAlvo       = r_semAlvo;
  assign bus.ocupado       = (r_estado != OCIOSO);
  assign bus.falha         = (r_estado == FALHA);
endmodule

// File: tb/tb_controle_exploracao.sv
// Directed bench for controle_exploracao: per-cycle vector table plus timeout and reset sequences.
module tb_controle_exploracao;
  import exploracao_pkg::*;

  typedef struct {
    logic   rst, hab, pv;
    coord_t px, py;
    logic   ma, fin;
    coord_t rx, ry;
    logic   pr;
    logic   novo;
    coord_t bx, by;
    logic   dv;
    coord_t dx, dy;
    logic   sem, ocu, fal;
  } vec_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad   = 0;
  vec_t tab[$];

  controle_exploracao_if #(.tamanhoDistancia(8)) bus ();

  controle_exploracao #(
    .tamanhoDistancia(8),
    .TIMEOUT_CICLOS  (16),
    .MAX_TENTATIVAS  (2)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.master)
  );

  always #5 clock = ~clock;

  function automatic vec_t v(input int rst, hab, pv, px, py, ma, fin, rx, ry, pr,
                             input int novo, bx, by, dv, dx, dy, sem, ocu, fal);
    vec_t r;
    r.rst = (rst != 0);  r.hab = (hab != 0); r.pv = (pv != 0);
    r.px  = 8'(px);      r.py  = 8'(py);
    r.ma  = (ma != 0);   r.fin = (fin != 0);
    r.rx  = 8'(rx);      r.ry  = 8'(ry);
    r.pr  = (pr != 0);
    r.novo = (novo != 0);
    r.bx  = 8'(bx);      r.by  = 8'(by);
    r.dv  = (dv != 0);
    r.dx  = 8'(dx);      r.dy  = 8'(dy);
    r.sem = (sem != 0);  r.ocu = (ocu != 0); r.fal = (fal != 0);
    return r;
  endfunction

  function automatic logic [36:0] obs();
    return {bus.novoDado, bus.buscaX, bus.buscaY, bus.destinoValido,
            bus.destinoX, bus.destinoY, bus.semAlvo, bus.ocupado, bus.falha};
  endfunction

  function automatic logic [36:0] esperado(input vec_t e);
    return {e.novo, e.bx, e.by, e.dv, e.dx, e.dy, e.sem, e.ocu, e.fal};
  endfunction

  task automatic chk(input string nome, input logic [36:0] act, input logic [36:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (novo,bx,by,dv,dx,dy,sem,ocu,fal)", nome, act, exp);
    end
  endtask

  task automatic drive(input vec_t e);
    reset                  = e.rst;
    bus.habilita           = e.hab;
    bus.posicaoValida      = e.pv;
    bus.posicaoX           = e.px;
    bus.posicaoY           = e.py;
    bus.malhaAtualizada    = e.ma;
    bus.operacaoFinalizada = e.fin;
    bus.resultadoX         = e.rx;
    bus.resultadoY         = e.ry;
    bus.destinoPronto      = e.pr;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    drive(v(1,0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0,0));

    // Nominal launch, held offer, handshake, then the owed follow-up finding no target.
    tab.push_back(v(1,0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0,0));
    tab.push_back(v(0,1,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0,0));
    tab.push_back(v(0,1,1,0,0,0,0,0,0,0, 1,0,0,0,0,0,0,1,0));
    tab.push_back(v(0,1,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,1,0));
    tab.push_back(v(0,1,0,0,0,0,1,2,3,0, 0,0,0,1,2,3,0,1,0));
    for (int i = 0; i < 5; i++)
      tab.push_back(v(0,1,0,0,0,0,1,7,7,0, 0,0,0,1,2,3,0,1,0));
    tab.push_back(v(0,1,0,0,0,0,1,7,7,1, 0,0,0,0,2,3,0,0,0));
    tab.push_back(v(0,1,0,0,0,0,0,0,0,0, 1,0,0,0,2,3,0,1,0));
    tab.push_back(v(0,1,0,0,0,0,0,0,0,0, 0,0,0,0,2,3,0,1,0));
    tab.push_back(v(0,1,0,0,0,0,1,0,0,0, 0,0,0,0,2,3,1,0,0));
    tab.push_back(v(0,1,0,0,0,0,0,0,0,0, 0,0,0,0,2,3,1,0,0));
    // No target at (4,4).
    tab.push_back(v(0,1,1,4,4,0,0,0,0,0, 1,4,4,0,2,3,0,1,0));
    tab.push_back(v(0,1,0,0,0,0,0,0,0,0, 0,4,4,0,2,3,0,1,0));
    tab.push_back(v(0,1,0,0,0,0,1,4,4,0, 0,4,4,0,2,3,1,0,0));
    tab.push_back(v(0,1,0,0,0,0,0,0,0,0, 1,4,4,0,2,3,0,1,0));
    tab.push_back(v(0,1,0,0,0,0,0,0,0,0, 0,4,4,0,2,3,0,1,0));
    tab.push_back(v(0,1,0,0,0,0,1,4,4,0, 0,4,4,0,2,3,1,0,0));
    tab.push_back(v(0,1,0,0,0,0,0,0,0,0, 0,4,4,0,2,3,1,0,0));
    // Stale completion level ignored, fresh edge with (5,1) delivered.
    tab.push_back(v(1,1,0,0,0,0,1,0,0,0, 0,0,0,0,0,0,0,0,0));
    tab.push_back(v(0,1,1,1,2,0,1,0,0,0, 1,1,2,0,0,0,0,1,0));
    tab.push_back(v(0,1,0,0,0,0,1,9,9,0, 0,1,2,0,0,0,0,1,0));
    tab.push_back(v(0,1,0,0,0,0,1,9,9,0, 0,1,2,0,0,0,0,1,0));
    tab.push_back(v(0,1,0,0,0,0,0,9,9,0, 0,1,2,0,0,0,0,1,0));
    tab.push_back(v(0,1,0,0,0,0,1,5,1,0, 0,1,2,1,5,1,0,1,0));
    tab.push_back(v(0,1,0,0,0,0,0,0,0,1, 0,1,2,0,5,1,0,0,0));
    tab.push_back(v(0,1,0,0,0,0,0,0,0,0, 1,1,2,0,5,1,0,1,0));
    // habilita low holds the launch; map update in AGUARDA owes a second search.
    tab.push_back(v(1,0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0,0));
    tab.push_back(v(0,0,1,3,3,0,0,0,0,0, 0,0,0,0,0,0,0,0,0));
    tab.push_back(v(0,1,0,0,0,0,0,0,0,0, 1,3,3,0,0,0,0,1,0));
    tab.push_back(v(0,1,0,0,0,0,0,0,0,0, 0,3,3,0,0,0,0,1,0));
    tab.push_back(v(0,1,0,0,0,1,0,0,0,0, 0,3,3,0,0,0,0,1,0));
    tab.push_back(v(0,1,0,0,0,0,1,6,0,0, 0,3,3,1,6,0,0,1,0));
    tab.push_back(v(0,1,0,0,0,0,0,0,0,1, 0,3,3,0,6,0,0,0,0));
    tab.push_back(v(0,1,0,0,0,0,0,0,0,0, 1,3,3,0,6,0,0,1,0));
    tab.push_back(v(0,1,0,0,0,0,0,0,0,0, 0,3,3,0,6,0,0,1,0));
    tab.push_back(v(0,1,0,0,0,0,1,3,3,0, 0,3,3,0,6,0,1,0,0));
    tab.push_back(v(0,1,0,0,0,0,0,0,0,0, 0,3,3,0,6,0,1,0,0));
    // Strobe coincident with the launch: exactly one extra search.
    tab.push_back(v(0,0,0,0,0,1,0,0,0,0, 0,3,3,0,6,0,1,0,0));
    tab.push_back(v(0,1,0,0,0,1,0,0,0,0, 1,3,3,0,6,0,0,1,0));
    tab.push_back(v(0,1,0,0,0,0,0,0,0,0, 0,3,3,0,6,0,0,1,0));
    tab.push_back(v(0,1,0,0,0,0,1,3,3,0, 0,3,3,0,6,0,1,0,0));
    tab.push_back(v(0,1,0,0,0,0,0,0,0,0, 1,3,3,0,6,0,0,1,0));
    tab.push_back(v(0,1,0,0,0,0,0,0,0,0, 0,3,3,0,6,0,0,1,0));
    tab.push_back(v(0,1,0,0,0,0,1,3,3,0, 0,3,3,0,6,0,1,0,0));
    tab.push_back(v(0,1,0,0,0,0,0,0,0,0, 0,3,3,0,6,0,1,0,0));
    // Position arriving in the launch cycle is searched directly.
    tab.push_back(v(0,0,1,8,9,0,0,0,0,0, 0,3,3,0,6,0,1,0,0));
    tab.push_back(v(0,1,1,10,11,0,0,0,0,0, 1,10,11,0,6,0,0,1,0));
    tab.push_back(v(0,1,0,0,0,0,0,0,0,0, 0,10,11,0,6,0,0,1,0));
    tab.push_back(v(0,1,0,0,0,0,1,10,11,0, 0,10,11,0,6,0,1,0,0));
    tab.push_back(v(0,1,0,0,0,0,0,0,0,0, 1,10,11,0,6,0,0,1,0));

    for (int i = 0; i < tab.size(); i++) begin
      drive(tab[i]);
      step();
      chk($sformatf("vec%0d", i), obs(), esperado(tab[i]));
    end

    // Timeout and retry: the engine never completes.
    drive(v(1,1,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0,0));
    step();
    chk("timeout_reset", obs(), 37'd0);
    drive(v(0,1,1,1,1,0,0,0,0,0, 0,0,0,0,0,0,0,0,0));
    step();
    chk("timeout_launch", obs(), esperado(v(0,0,0,0,0,0,0,0,0,0, 1,1,1,0,0,0,0,1,0)));
    drive(v(0,1,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0,0));
    for (int k = 1; k <= 40; k++) begin
      step();
      chk($sformatf("timeout_k%0d", k), obs(),
          esperado(v(0,0,0,0,0,0,0,0,0,0, (k == 16), 1,1,0,0,0,0,1, (k >= 32))));
    end
    for (int k = 0; k < 8; k++) begin
      drive(v(0,1,(k % 2 == 0),5,5,(k % 2 == 1),0,0,0,0, 0,0,0,0,0,0,0,0,0));
      step();
      chk($sformatf("falha_hold%0d", k), obs(), esperado(v(0,0,0,0,0,0,0,0,0,0, 0,1,1,0,0,0,0,1,1)));
    end
    drive(v(1,1,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0,0));
    step();
    chk("falha_cleared", obs(), 37'd0);

    // Reset in AGUARDA aborts; a fresh position is needed afterwards.
    drive(v(0,1,1,2,2,0,0,0,0,0, 0,0,0,0,0,0,0,0,0));
    step();
    chk("abort_launch", obs(), esperado(v(0,0,0,0,0,0,0,0,0,0, 1,2,2,0,0,0,0,1,0)));
    drive(v(0,1,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0,0));
    step();
    step();
    chk("abort_wait", obs(), esperado(v(0,0,0,0,0,0,0,0,0,0, 0,2,2,0,0,0,0,1,0)));
    drive(v(1,1,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0,0));
    step();
    chk("abort_reset", obs(), 37'd0);
    drive(v(0,1,0,0,0,0,1,7,7,0, 0,0,0,0,0,0,0,0,0));
    step();
    chk("abort_late_fin", obs(), 37'd0);
    drive(v(0,1,0,0,0,1,0,0,0,0, 0,0,0,0,0,0,0,0,0));
    step();
    chk("abort_no_pos1", obs(), 37'd0);
    drive(v(0,1,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0,0));
    step();
    chk("abort_no_pos2", obs(), 37'd0);
    drive(v(0,1,1,2,2,0,0,0,0,0, 0,0,0,0,0,0,0,0,0));
    step();
    chk("abort_relaunch", obs(), esperado(v(0,0,0,0,0,0,0,0,0,0, 1,2,2,0,0,0,0,1,0)));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
